// File: rtl/dragon_body_pkg.sv
// Shared dragon definitions, common to the head stage and the body shifter.
// Holds the position/direction widths, the direction encoding and the
// default number of body segment slots.
package dragon_body_pkg;

  localparam int POS_W = 8;   // {x[3:0], y[3:0]}
  localparam int DIR_W = 2;
  localparam int LEN_W = 4;   // enough for up to 15 slots
  localparam int DEFAULT_MAX_SEGMENTS = 7;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

endpackage

// File: rtl/dragon_segment_reg.sv
// One body segment slot: a position + direction register that loads its
// input when shift_en is high and holds otherwise.
// Ports:
//   clk, reset       system clock, asynchronous active-low reset
//   shift_en         load pos_in/dir_in on this edge
//   pos_in, dir_in   value from the slot nearer the head (or the head itself)
//   pos, dir         stored slot value
module dragon_segment_reg
  import dragon_body_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [POS_W-1:0] pos_in,
  input  logic [DIR_W-1:0] dir_in,
  output logic [POS_W-1:0] pos,
  output logic [DIR_W-1:0] dir
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos <= '0;
      dir <= '0;
    end else if (shift_en) begin
      pos <= pos_in;
      dir <= dir_in;
    end
  end

endmodule

// File: rtl/dragon_body.sv
// Dragon body shifter. Follows the head: whenever the head position changes,
// the previous head position/direction is pushed into slot 0 and every slot
// moves one place down the chain. body_len selects how many slots are live;
// grow/shrink pulses adjust it. A registered collision flag reports the head
// landing on a live segment.
// Ports:
//   clk, reset             system clock, asynchronous active-low reset
//   head_pos, head_dir     current head position/direction
//   grow, shrink           single-cycle length requests
//   body_pos, body_dir     packed slot contents, slot 0 in the low bits
//   body_active            thermometer mask of live slots
//   body_len               live slot count
//   full, empty            body_len at MAX_SEGMENTS / at zero
//   collision              head matched a live slot on the previous cycle
module dragon_body
  import dragon_body_pkg::*;
#(
  parameter int MAX_SEGMENTS = DEFAULT_MAX_SEGMENTS,
  parameter int INIT_LEN     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [POS_W-1:0]          head_pos,
  input  logic [DIR_W-1:0]          head_dir,
  input  logic                      grow,
  input  logic                      shrink,
  output logic [POS_W*MAX_SEGMENTS-1:0] body_pos,
  output logic [DIR_W*MAX_SEGMENTS-1:0] body_dir,
  output logic [MAX_SEGMENTS-1:0]   body_active,
  output logic [LEN_W-1:0]          body_len,
  output logic                      full,
  output logic                      empty,
  output logic                      collision
);

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_SEGMENTS);
  localparam logic [LEN_W-1:0] INIT_VAL = LEN_W'(INIT_LEN);

  logic [POS_W-1:0] prev_pos;
  logic [DIR_W-1:0] prev_dir;
  logic             move;
  logic             grow_pending;
  logic             grow_pending_next;
  logic [LEN_W-1:0] len_next;
  logic             hit;
  logic [POS_W-1:0] slot_pos [MAX_SEGMENTS];
  logic [DIR_W-1:0] slot_dir [MAX_SEGMENTS];

  assign move  = (head_pos != prev_pos);
  assign full  = (body_len == MAX_LEN);
  assign empty = (body_len == '0);

  // Every slot shifts on a move, live or not, so inactive slots keep the
  // trail and a later grow exposes a valid position immediately.
  for (genvar i = 0; i < MAX_SEGMENTS; i++) begin : g_slot
    logic [POS_W-1:0] pos_in;
    logic [DIR_W-1:0] dir_in;

    if (i == 0) begin : g_first
      assign pos_in = prev_pos;
      assign dir_in = prev_dir;
    end else begin : g_chain
      assign pos_in = slot_pos[i-1];
      assign dir_in = slot_dir[i-1];
    end

    dragon_segment_reg u_seg (
      .clk      (clk),
      .reset    (reset),
      .shift_en (move),
      .pos_in   (pos_in),
      .dir_in   (dir_in),
      .pos      (slot_pos[i]),
      .dir      (slot_dir[i])
    );

    assign body_pos[POS_W*i +: POS_W] = slot_pos[i];
    assign body_dir[DIR_W*i +: DIR_W] = slot_dir[i];
    assign body_active[i]             = (LEN_W'(i) < body_len);
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_SEGMENTS; i++) begin
      if (body_active[i] && (head_pos == slot_pos[i])) hit = 1'b1;
    end
  end

  // Length control. A lone shrink wins over any pending grow; grow together
  // with shrink is a no-op for both. A grow that would land on a full body
  // (including one filled by this very move) is dropped.
  always_comb begin
    len_next          = body_len;
    grow_pending_next = grow_pending;
    if (shrink && !grow) begin
      grow_pending_next = 1'b0;
      if (body_len != '0) len_next = body_len - 1'b1;
    end else begin
      if (move && grow_pending && (body_len < MAX_LEN)) begin
        len_next          = body_len + 1'b1;
        grow_pending_next = 1'b0;
      end
      if (grow && !shrink && (len_next != MAX_LEN)) grow_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pos     <= '0;
      prev_dir     <= '0;
      body_len     <= INIT_VAL;
      grow_pending <= 1'b0;
      collision    <= 1'b0;
    end else begin
      prev_pos     <= head_pos;
      prev_dir     <= head_dir;
      body_len     <= len_next;
      grow_pending <= grow_pending_next;
      collision    <= hit;
    end
  end

endmodule
